// File: rtl/mult_div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit_pkg
//  Description : Shared CPU definitions: MDU operation codes, default MDU
//                latencies, and the ALU / NPC operation codes of the E stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_div_unit_pkg;

    // Multiply/divide unit operations (MDOp)
    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MTHI  = 4'd5,
        MD_MTLO  = 4'd6,
        MD_MFHI  = 4'd7,
        MD_MFLO  = 4'd8
    } md_op_e;

    // Default busy periods of the multiply/divide unit, in clock cycles
    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // ALU operations
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL = 4'd8,
        ALU_SRL = 4'd9,
        ALU_SRA = 4'd10,
        ALU_LUI = 4'd11
    } alu_op_e;

    // Next-PC selection
    typedef enum logic [2:0] {
        NPC_PC4    = 3'd0,
        NPC_BRANCH = 3'd1,
        NPC_JUMP   = 3'd2,
        NPC_JREG   = 3'd3
    } npc_op_e;

endpackage : mult_div_unit_pkg
`default_nettype wire

// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : mult_div_unit
//  Description : E-stage multiply/divide unit with HI/LO registers. The result
//                is computed at acceptance, held in temporaries, and committed
//                to HI/LO when the busy counter expires. Both cycle counts
//                must be at least 1.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDout
);

    localparam int c_CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        res_hi_q, res_hi_d;
    logic [31:0]        res_lo_q, res_lo_d;
    logic               res_wr_q, res_wr_d;   // pending result is to be committed

    logic        w_accept;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [31:0] w_div_b;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_qmag;
    logic [31:0] w_rmag;
    logic [31:0] w_quot_s;
    logic [31:0] w_rem_s;
    logic [31:0] w_quot_u;
    logic [31:0] w_rem_u;

    assign busy     = (cnt_q != '0);
    assign w_accept = start && !busy;

    // 64-bit products; sign extension makes the truncated product exact
    assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // A zero divisor is replaced by 1 so the datapath never divides by zero;
    // the result is discarded in that case anyway.
    assign w_div_b = (B == 32'd0) ? 32'd1 : B;

    // Signed division on magnitudes: quotient truncates toward zero and the
    // remainder takes the dividend's sign. 0x80000000 / -1 wraps to 0x80000000.
    assign w_mag_a  = A[31] ? (32'd0 - A) : A;
    assign w_mag_b  = w_div_b[31] ? (32'd0 - w_div_b) : w_div_b;
    assign w_qmag   = w_mag_a / w_mag_b;
    assign w_rmag   = w_mag_a % w_mag_b;
    assign w_quot_s = (A[31] ^ w_div_b[31]) ? (32'd0 - w_qmag) : w_qmag;
    assign w_rem_s  = A[31] ? (32'd0 - w_rmag) : w_rmag;
    assign w_quot_u = A / w_div_b;
    assign w_rem_u  = A % w_div_b;

    // Next-state: count down and commit, or accept a new operation when idle
    always_comb begin
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_wr_d = res_wr_q;

        if (busy) begin
            cnt_d = cnt_q - 1'b1;
            if ((cnt_q == c_CNT_W'(1)) && res_wr_q) begin
                hi_d = res_hi_q;
                lo_d = res_lo_q;
            end
        end else if (w_accept) begin
            case (MDOp)
                MD_MULT: begin
                    res_hi_d = w_prod_s[63:32];
                    res_lo_d = w_prod_s[31:0];
                    res_wr_d = 1'b1;
                    cnt_d    = c_CNT_W'(MULT_CYCLES);
                end
                MD_MULTU: begin
                    res_hi_d = w_prod_u[63:32];
                    res_lo_d = w_prod_u[31:0];
                    res_wr_d = 1'b1;
                    cnt_d    = c_CNT_W'(MULT_CYCLES);
                end
                MD_DIV: begin
                    res_hi_d = w_rem_s;
                    res_lo_d = w_quot_s;
                    res_wr_d = (B != 32'd0);
                    cnt_d    = c_CNT_W'(DIV_CYCLES);
                end
                MD_DIVU: begin
                    res_hi_d = w_rem_u;
                    res_lo_d = w_quot_u;
                    res_wr_d = (B != 32'd0);
                    cnt_d    = c_CNT_W'(DIV_CYCLES);
                end
                MD_MTHI: hi_d = A;
                MD_MTLO: lo_d = A;
                default: ;
            endcase
        end
    end

    // State registers; reset clears HI/LO and aborts any pending result
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            res_wr_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_wr_q <= res_wr_d;
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;

    // Move-from read port
    always_comb begin
        MDout = 32'd0;
        case (MDOp)
            MD_MFHI: MDout = hi_q;
            MD_MFLO: MDout = lo_q;
            default: MDout = 32'd0;
        endcase
    end

endmodule : mult_div_unit
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_div_unit
//  Description : Scoreboard bench for mult_div_unit: directed mult/div/move
//                vectors, busy-while-start, divide by zero, reset abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDout;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    mult_div_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .start(start),
        .MDOp (MDOp),
        .A    (A),
        .B    (B),
        .busy (busy),
        .HI   (HI),
        .LO   (LO),
        .MDout(MDout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push(input string name, input logic [31:0] hi, input logic [31:0] lo, input int cyc);
        exp_t e;
        e.name   = name;
        e.hi     = hi;
        e.lo     = lo;
        e.cycles = cyc;
        sb.push_back(e);
    endtask

    // One-cycle start pulse; operands are scrambled afterwards
    task automatic issue(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
        MDOp  = MD_NONE;
        A     = $urandom;
        B     = $urandom;
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (!done) begin
            n_errors++;
            $display("FAIL %s_timeout: busy still %0b, expected 0 within 40 cycles", name, busy);
        end
        @(negedge clk);
        #1;
    endtask

    // Monitor: when busy falls, the committed HI/LO and busy length are scored
    initial begin
        bit   prev = 1'b0;
        int   blen = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev = 1'b0;
                blen = 0;
            end else if (busy) begin
                prev = 1'b1;
                blen++;
            end else if (prev) begin
                prev = 1'b0;
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: got completion HI=%h LO=%h, expected none", HI, LO);
                end else begin
                    e = sb.pop_front();
                    chk({e.name, "_hi"}, HI, e.hi);
                    chk({e.name, "_lo"}, LO, e.lo);
                    chk({e.name, "_busy_len"}, 32'(blen), 32'(e.cycles));
                end
                blen = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        start = 1'b0;
        MDOp  = MD_NONE;
        A     = 32'd0;
        B     = 32'd0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        chk("rst_hi",    HI,           32'd0);
        chk("rst_lo",    LO,           32'd0);
        chk("rst_busy",  32'(busy),    32'd0);
        chk("rst_mdout", MDout,        32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        // Seed HI/LO with move-to ops
        issue(MD_MTLO, 32'h0BAD_F00D, 32'd0);
        chk("mtlo_lo", LO, 32'h0BAD_F00D);
        issue(MD_MTHI, 32'h1111_1111, 32'd0);
        chk("mthi_hi", HI, 32'h1111_1111);
        chk("mthi_nobusy", 32'(busy), 32'd0);

        // MULT; an MTLO during busy is ignored and MFLO shows the old LO
        push("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5);
        issue(MD_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
        chk("mult_busy", 32'(busy), 32'd1);
        start = 1'b1;
        MDOp  = MD_MTLO;
        A     = 32'h0000_DEAD;
        @(posedge clk);
        #1;
        start = 1'b0;
        MDOp  = MD_MFLO;
        #1;
        chk("mflo_during_busy", MDout, 32'h0BAD_F00D);
        chk("mtlo_ignored_lo", LO, 32'h0BAD_F00D);
        chk("mult_still_busy", 32'(busy), 32'd1);
        MDOp = MD_NONE;
        wait_idle("mult");

        push("multu", 32'h0000_0001, 32'hFFFF_FFFE, 5);
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
        wait_idle("multu");

        push("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        issue(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
        wait_idle("div_neg");

        push("divu", 32'h0000_0001, 32'h0000_0003, 10);
        issue(MD_DIVU, 32'h0000_0007, 32'h0000_0002);
        wait_idle("divu");

        // 100 / -7 = -14 remainder 2
        push("div_negb", 32'h0000_0002, 32'hFFFF_FFF2, 10);
        issue(MD_DIV, 32'd100, 32'hFFFF_FFF9);
        wait_idle("div_negb");

        // MTHI then divide by zero: HI/LO untouched, full busy period
        issue(MD_MTHI, 32'h1234_5678, 32'd0);
        chk("mthi2_hi", HI, 32'h1234_5678);
        start = 1'b1;
        MDOp  = MD_MFHI;
        #1;
        chk("mfhi_mdout", MDout, 32'h1234_5678);
        @(posedge clk);
        #1;
        start = 1'b0;
        MDOp  = MD_NONE;
        chk("mfhi_nochange", HI, 32'h1234_5678);
        push("div_zero", 32'h1234_5678, 32'hFFFF_FFF2, 10);
        issue(MD_DIV, 32'h0000_0064, 32'd0);
        wait_idle("div_zero");

        // Reset mid-division aborts it
        issue(MD_DIVU, 32'd9, 32'd2);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_busy_before", 32'(busy), 32'd1);
        #1 reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi",   HI,        32'd0);
        chk("abort_lo",   LO,        32'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        chk("post_abort_hi",   HI,        32'd0);
        chk("post_abort_lo",   LO,        32'd0);
        chk("post_abort_busy", 32'(busy), 32'd0);

        // First op after reset behaves as from power-up: 3 * -4 = -12
        push("mult_after_rst", 32'hFFFF_FFFF, 32'hFFFF_FFF4, 5);
        issue(MD_MULT, 32'd3, 32'hFFFF_FFFC);
        wait_idle("mult_after_rst");

        repeat (3) @(posedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mult_div_unit
`default_nettype wire

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy length in cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy length in cycles for div/divu.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on posedge clk.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port start, input, 1: E-stage instruction valid for MDOp.
REQ-006 SHALL have port MDOp, input, 4: operation code, encoded per shared package.
REQ-007 SHALL have port A, input, 32: rs operand (forwarded GRF RD1).
REQ-008 SHALL have port B, input, 32: rt operand (forwarded GRF RD2).
REQ-009 SHALL have port busy, output, 1: registered, high while a mult/div is in flight.
REQ-010 SHALL have port HI, output, 32: current HI register.
REQ-011 SHALL have port LO, output, 32: current LO register.
REQ-012 SHALL have port MDout, output, 32: HI when MDOp=MFHI, LO when MDOp=MFLO, else 0; combinational.

Function
REQ-013 SHALL support ops NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO; all other codes act as NONE.
REQ-014 SHALL accept an op only on a cycle with start=1 and busy=0; start while busy=1 is ignored and changes no state.
REQ-015 On accepted MULT/MULTU/DIV/DIVU at edge E0, SHALL latch operands, compute the result into internal temporaries, and load the cycle counter with MULT_CYCLES or DIV_CYCLES.
REQ-016 busy SHALL equal (counter != 0); it is high for exactly N cycles after E0.
REQ-017 Counter SHALL decrement by 1 per edge while nonzero; at the edge where it moves 1->0, HI/LO SHALL load the result, so the new values are visible in the first cycle with busy=0.
REQ-018 MULT: {HI,LO} = 64-bit signed product of A and B; MULTU: unsigned product.
REQ-019 DIV: LO = signed quotient truncated toward zero, HI = signed remainder carrying the dividend's sign; DIVU: unsigned quotient and remainder.
REQ-020 Division with B=0 SHALL still run the full DIV_CYCLES busy period and leave HI and LO unchanged.
REQ-021 Accepted MTHI SHALL write HI<=A at that edge; MTLO SHALL write LO<=A; visible the next cycle; no busy.
REQ-022 MFHI/MFLO SHALL NOT change state; while busy=1, MDout shows pre-operation HI/LO. The stall unit holds mf*/mt* and new mult/div in D while (start && E-stage op is mult/div) || busy.
REQ-023 Operand changes on A/B after E0 SHALL NOT affect the in-flight result.

Reset
REQ-024 While reset=0, asynchronously and regardless of clk, SHALL force HI=0, LO=0, counter=0, busy=0, and clear the latched temporaries.
REQ-025 Reset asserted mid-operation SHALL abort it; the pending result is discarded and never written.
REQ-026 After reset deasserts, the first accepted op SHALL behave exactly as from power-up.

Structure
REQ-027 MDOp encodings and the default cycle counts SHALL live in the shared CPU definitions package, with the ALU/NPC op codes.
REQ-028 SHALL be a single module with no sub-modules; the counter and the HI/LO registers are local state.
REQ-029 The unit SHALL instantiate in the E stage beside the ALU; busy and start SHALL route to the hazard/stall unit.

Verification
REQ-030 MULT A=0xFFFFFFFF, B=0x00000002 -> busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
REQ-031 MULTU with the same operands -> after 5 cycles, HI=0x00000001, LO=0xFFFFFFFE.
REQ-032 DIV A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU A=7, B=2 -> LO=3, HI=1.
REQ-033 MTHI A=0x12345678, then DIV B=0 -> busy 10 cycles; HI stays 0x12345678 and LO is unchanged.
REQ-034 During MULT busy, drive start=1 with MTLO A=0xDEAD -> ignored; LO ends as the product. MFLO during busy -> MDout shows the old LO.
REQ-035 Start DIV, pull reset low at cycle 4 asynchronously -> busy=0, HI=LO=0 immediately; no later write after release.
